fifo_rptr_empty: RTL and testbench

//  Read-domain pointer and empty logic of the async FIFO; directly downstream of the write-pointer synchronizer.
//  - Consumes the synchronized Gray write pointer.
//  - Owns the read pointer (binary + Gray) and produces the RAM read address.
//  - Produces registered empty, almost-empty and occupancy flags for the read-side consumer.
//  - Gray rptr output feeds the read-to-write synchronizer.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_gray_cnt.sv | 44 ++++
 rtl/fifo_rptr_empty.sv | 91 +++++++++
 tb/tb_fifo_rptr_empty.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared async-FIFO pointer types, depth and Gray/binary helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int unsigned PTR_WIDTH_DEF = 8;
  localparam int unsigned DEPTH         = 2 ** PTR_WIDTH_DEF;
  localparam int unsigned MAX_W         = 32;

  typedef logic [PTR_WIDTH_DEF:0] ptr_t;

  // Width-agnostic: callers zero-extend to MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_gray_cnt.sv
// ============================================================================
// Module : fifo_gray_cnt
// Brief  : Registered binary + Gray pointer counter with enable; exposes the
//          next-state values for flag logic that must look one step ahead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_gray_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = PTR_WIDTH_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-2:0] addr,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_nxt,
  output logic [WIDTH-1:0] gray_nxt
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;

  assign bin_nxt  = r_bin + WIDTH'(en);
  assign gray_nxt = WIDTH'(bin2gray(MAX_W'(bin_nxt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= bin_nxt;
      r_gray <= gray_nxt;
    end
  end

  assign addr = r_bin[WIDTH-2:0];
  assign gray = r_gray;

endmodule

`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
// ============================================================================
// Module : fifo_rptr_empty
// Brief  : Read-domain pointer, empty / almost-empty / occupancy flags.
//          Optional macro RPTR_UNDERFLOW_EN enables the sticky underflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                 rclk,
  input  logic                 r_rst_n,
  input  logic                 rinc,
  input  logic [PTR_WIDTH:0]   wptr_sync,
  output logic [PTR_WIDTH:0]   rptr,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [PTR_WIDTH:0]   rcount,
  output logic                 runderflow
);

  localparam logic [PTR_WIDTH:0] C_AE_THRESH = (PTR_WIDTH + 1)'(AE_THRESH);

  logic               w_rd_ok;
  logic [PTR_WIDTH:0] w_rbin_nxt;
  logic [PTR_WIDTH:0] w_rgray_nxt;
  logic [PTR_WIDTH:0] w_wbin_s;
  logic [PTR_WIDTH:0] w_occ_nxt;

  logic               r_rempty;
  logic               r_ralmost_empty;
  logic [PTR_WIDTH:0] r_rcount;

  assign w_rd_ok = rinc & ~r_rempty;

  fifo_gray_cnt #(
    .WIDTH    (PTR_WIDTH + 1)
  ) u_rptr_cnt (
    .clk      (rclk),
    .rst_n    (r_rst_n),
    .en       (w_rd_ok),
    .addr     (raddr),
    .gray     (rptr),
    .bin_nxt  (w_rbin_nxt),
    .gray_nxt (w_rgray_nxt)
  );

  // Modular subtraction keeps occupancy correct across pointer wrap.
  assign w_wbin_s  = (PTR_WIDTH + 1)'(gray2bin(MAX_W'(wptr_sync)));
  assign w_occ_nxt = w_wbin_s - w_rbin_nxt;

  always_ff @(posedge rclk) begin
    if (!r_rst_n) begin
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_rcount        <= '0;
    end else begin
      r_rempty        <= (w_rgray_nxt == wptr_sync);
      r_ralmost_empty <= (w_occ_nxt <= C_AE_THRESH);
      r_rcount        <= w_occ_nxt;
    end
  end

  assign rempty        = r_rempty;
  assign ralmost_empty = r_ralmost_empty;
  assign rcount        = r_rcount;

`ifdef RPTR_UNDERFLOW_EN
  logic r_runderflow;

  always_ff @(posedge rclk) begin
    if (!r_rst_n) begin
      r_runderflow <= 1'b0;
    end else if (rinc & r_rempty) begin
      r_runderflow <= 1'b1;
    end
  end

  assign runderflow = r_runderflow;
`else
  assign runderflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
// Scoreboard bench for fifo_rptr_empty: integer-count reference model drives
// expectations into a queue that a per-cycle monitor drains and compares.
`default_nettype none

module tb_fifo_rptr_empty;

  logic       rclk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       rinc = 1'b0;
  logic [8:0] wptr_sync = '0;
  logic [8:0] rptr;
  logic [7:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [8:0] rcount;
  logic       runderflow;

  fifo_rptr_empty #(
    .PTR_WIDTH     (8),
    .AE_THRESH     (4)
  ) dut (
    .rclk          (rclk),
    .r_rst_n       (r_rst_n),
    .rinc          (rinc),
    .wptr_sync     (wptr_sync),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [8:0] rptr;
    logic [7:0] raddr;
    logic       empty;
    logic       aempty;
    logic [8:0] count;
    logic       uf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference state: total words read / written since reset as plain integers.
  int m_rd = 0;
  int wtot = 0;
  bit m_empty = 1'b1;
  bit m_uf = 1'b0;

  function automatic logic [8:0] gray9(input int v);
    logic [8:0] b;
    b = 9'(v % 512);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic step(input bit rst_n_i, input bit rinc_i, input int w_i);
    exp_t e;
    int   occ;
    @(negedge rclk);
    r_rst_n   = rst_n_i;
    rinc      = rinc_i;
    wptr_sync = gray9(w_i);
    if (!rst_n_i) begin
      m_rd = 0; m_empty = 1'b1; m_uf = 1'b0; occ = 0;
    end else begin
`ifdef RPTR_UNDERFLOW_EN
      if (rinc_i && m_empty) m_uf = 1'b1;
`endif
      if (rinc_i && !m_empty) m_rd++;
      occ     = w_i - m_rd;
      m_empty = (occ == 0);
    end
    e.rptr   = gray9(m_rd);
    e.raddr  = 8'(m_rd % 256);
    e.empty  = m_empty;
    e.aempty = (occ <= 4);
    e.count  = 9'(occ);
    e.uf     = m_uf;
    q.push_back(e);
  endtask

  task automatic do_reset();
    wtot = 0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  always @(posedge rclk) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rptr",          32'(rptr),          32'(e.rptr));
      chk("raddr",         32'(raddr),         32'(e.raddr));
      chk("rempty",        32'(rempty),        32'(e.empty));
      chk("ralmost_empty", 32'(ralmost_empty), 32'(e.aempty));
      chk("rcount",        32'(rcount),        32'(e.count));
      chk("runderflow",    32'(runderflow),    32'(e.uf));
    end
  end

  initial begin
    int rd_pct;
    // Reset, then reads against an empty FIFO must not move the pointer.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 0);
    // Five words visible, then one read.
    wtot = 5;
    step(1'b1, 1'b0, wtot);
    step(1'b1, 1'b1, wtot);
    step(1'b1, 1'b0, wtot);
    // Two words, back-to-back reads, then a read while empty.
    do_reset();
    wtot = 2;
    step(1'b1, 1'b0, wtot);
    repeat (3) step(1'b1, 1'b1, wtot);
    step(1'b1, 1'b0, wtot);
    // Wrap: writer stays a few words ahead until 256 total.
    do_reset();
    repeat (270) begin
      wtot = (m_rd + 3 < 256) ? m_rd + 3 : 256;
      step(1'b1, 1'b1, wtot);
    end
    // Full, then drain completely.
    do_reset();
    wtot = 256;
    step(1'b1, 1'b0, wtot);
    step(1'b1, 1'b0, wtot);
    repeat (262) step(1'b1, 1'b1, wtot);
    // Randomized traffic with varying read pressure and occasional resets.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      rd_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 90);
      repeat (500) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          wtot += $urandom_range(0, 2);
          if (wtot > m_rd + 256) wtot = m_rd + 256;
          step(1'b1, ($urandom_range(0, 99) < rd_pct), wtot);
        end
      end
    end
    // Final underflow-stickiness probe followed by reset.
    do_reset();
    step(1'b1, 1'b1, 0);
    wtot = 3;
    repeat (4) step(1'b1, 1'b1, wtot);
    do_reset();
    step(1'b1, 1'b0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge rclk);
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
